// File: rtl/tl_coh_pkg.sv
// Shared TileLink-C coherence definitions for the L1 probe path.
package tl_coh_pkg;

   // B / C channel opcodes
   localparam logic [2:0] TL_B_PROBE          = 3'd6;
   localparam logic [2:0] TL_C_PROBE_ACK      = 3'd4;
   localparam logic [2:0] TL_C_PROBE_ACK_DATA = 3'd5;

   // Probe cap params (3 is folded into toN by the shrink logic)
   localparam logic [2:0] CAP_TO_T = 3'd0;
   localparam logic [2:0] CAP_TO_B = 3'd1;
   localparam logic [2:0] CAP_TO_N = 3'd2;

   // ProbeAck report params
   localparam logic [2:0] REP_TTOB = 3'd0;
   localparam logic [2:0] REP_TTON = 3'd1;
   localparam logic [2:0] REP_BTON = 3'd2;
   localparam logic [2:0] REP_TTOT = 3'd3;
   localparam logic [2:0] REP_BTOB = 3'd4;
   localparam logic [2:0] REP_NTON = 3'd5;

   // Line coherence state as held in the tag array
   typedef enum logic [1:0] {
      COH_N = 2'd0,
      COH_B = 2'd1,
      COH_T = 2'd2
   } coh_state_e;

   // Probe handler FSM
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_DECIDE,
      ST_ACK,
      ST_DREQ,
      ST_DBEAT
   } probe_state_e;

endpackage

// File: rtl/probe_shrink_calc.sv
// Combinational permission shrink: maps probe cap and current line state to
// the ProbeAck report, the downgraded state and whether dirty data leaves.
module probe_shrink_calc
   import tl_coh_pkg::*;
(
   input  logic [2:0] cap,
   input  logic [1:0] state,
   input  logic       dirty,
   output logic [2:0] report_param,
   output logic [1:0] new_state,
   output logic       new_dirty,
   output logic       needs_data,
   output logic       upd_en
);

   // Decode the downgrade; unknown states answer NtoN and are left untouched
   always_comb begin
      report_param = REP_NTON;
      new_state    = state;
      new_dirty    = dirty;
      needs_data   = 1'b0;
      case (state)
         COH_T: begin
            if (cap == CAP_TO_T) begin
               report_param = REP_TTOT;
            end else if (cap == CAP_TO_B) begin
               report_param = REP_TTOB;
               new_state    = COH_B;
               new_dirty    = 1'b0;
               needs_data   = dirty;
            end else begin
               report_param = REP_TTON;
               new_state    = COH_N;
               new_dirty    = 1'b0;
               needs_data   = dirty;
            end
         end
         COH_B: begin
            if (cap == CAP_TO_T || cap == CAP_TO_B) begin
               report_param = REP_BTOB;
            end else begin
               report_param = REP_BTON;
               new_state    = COH_N;
               new_dirty    = 1'b0;
            end
         end
         default: begin
            report_param = REP_NTON;
         end
      endcase
      upd_en = (new_state != state) || (new_dirty != dirty);
   end

endmodule

// File: rtl/probe_responder.sv
// Client-side TileLink-C Probe handler: accepts a Probe on B, looks up and
// downgrades the line in the tag array, answers with ProbeAck or a 4-beat
// ProbeAckData on C.
module probe_responder
   import tl_coh_pkg::*;
#(
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned BEATS  = 4
) (
   input  logic              tilelink_clk_i,
   input  logic              tilelink_rst_ni,
   input  logic              b_valid_i,
   output logic              b_ready_o,
   input  logic [2:0]        b_opcode_i,
   input  logic [2:0]        b_param_i,
   input  logic [2:0]        b_size_i,
   input  logic              b_source_i,
   input  logic [ADDR_W-1:0] b_address_i,
   output logic              c_valid_o,
   input  logic              c_ready_i,
   output logic [2:0]        c_opcode_o,
   output logic [2:0]        c_param_o,
   output logic [2:0]        c_size_o,
   output logic              c_source_o,
   output logic [ADDR_W-1:0] c_address_o,
   output logic [127:0]      c_data_o,
   output logic              c_corrupt_o,
   output logic              tag_req_o,
   output logic [ADDR_W-1:0] tag_addr_o,
   input  logic [1:0]        tag_state_i,
   input  logic              tag_dirty_i,
   output logic              upd_valid_o,
   output logic [1:0]        upd_state_o,
   output logic              upd_dirty_o,
   output logic              dr_req_o,
   output logic [ADDR_W-1:0] dr_addr_o,
   input  logic [127:0]      dr_data_i,
   input  logic              probe_blk_i,
   output logic              busy_o,
   output logic              illegal_o
);

   localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

   probe_state_e      state_q, state_d;
   logic [1:0]        beat_q;
   logic [2:0]        cap_q;
   logic [2:0]        c_opcode_q, c_param_q, c_size_q;
   logic              c_source_q;
   logic [ADDR_W-1:0] c_addr_q;
   logic [127:0]      data_q;
   logic              fresh_q;
   logic              illegal_q;
   logic              b_accept;

   logic [2:0]        calc_param;
   logic [1:0]        calc_state;
   logic              calc_dirty;
   logic              calc_needs_data;
   logic              calc_upd_en;

   assign b_accept = (state_q == ST_IDLE) && b_valid_i && !probe_blk_i;

   probe_shrink_calc u_calc (
      .cap          (cap_q),
      .state        (tag_state_i),
      .dirty        (tag_dirty_i),
      .report_param (calc_param),
      .new_state    (calc_state),
      .new_dirty    (calc_dirty),
      .needs_data   (calc_needs_data),
      .upd_en       (calc_upd_en)
   );

   // FSM state register
   always_ff @(posedge tilelink_clk_i) begin
      if (!tilelink_rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-state strobes
   always_comb begin
      state_d     = state_q;
      b_ready_o   = 1'b0;
      tag_req_o   = 1'b0;
      upd_valid_o = 1'b0;
      dr_req_o    = 1'b0;
      c_valid_o   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            b_ready_o = !probe_blk_i;
            if (b_accept && b_opcode_i == TL_B_PROBE) begin
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            tag_req_o = 1'b1;
            state_d   = ST_DECIDE;
         end
         ST_DECIDE: begin
            upd_valid_o = calc_upd_en;
            state_d     = calc_needs_data ? ST_DREQ : ST_ACK;
         end
         ST_ACK: begin
            c_valid_o = 1'b1;
            if (c_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_DREQ: begin
            dr_req_o = 1'b1;
            state_d  = ST_DBEAT;
         end
         ST_DBEAT: begin
            c_valid_o = 1'b1;
            if (c_ready_i) begin
               state_d = (beat_q == LAST_BEAT) ? ST_IDLE : ST_DREQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Probe field capture, response latching and beat sequencing
   always_ff @(posedge tilelink_clk_i) begin
      if (!tilelink_rst_ni) begin
         beat_q     <= '0;
         cap_q      <= '0;
         c_opcode_q <= '0;
         c_param_q  <= '0;
         c_size_q   <= '0;
         c_source_q <= 1'b0;
         c_addr_q   <= '0;
         data_q     <= '0;
         fresh_q    <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         fresh_q   <= 1'b0;
         if (b_accept) begin
            cap_q      <= b_param_i;
            c_size_q   <= b_size_i;
            c_source_q <= b_source_i;
            c_addr_q   <= b_address_i;
            beat_q     <= '0;
            data_q     <= '0;
            illegal_q  <= (b_opcode_i != TL_B_PROBE);
         end
         if (state_q == ST_DECIDE) begin
            c_opcode_q <= calc_needs_data ? TL_C_PROBE_ACK_DATA : TL_C_PROBE_ACK;
            c_param_q  <= calc_param;
         end
         if (state_q == ST_DREQ) begin
            fresh_q <= 1'b1;
         end
         if (fresh_q) begin
            data_q <= dr_data_i;
         end
         if (state_q == ST_DBEAT && c_ready_i && beat_q != LAST_BEAT) begin
            beat_q <= beat_q + 2'd1;
         end
      end
   end

   // Beat data is forwarded straight from the array in the first DBEAT cycle
   // and then held from data_q so it stays stable while the beat stalls.
   assign c_data_o    = fresh_q ? dr_data_i : data_q;
   assign c_opcode_o  = c_opcode_q;
   assign c_param_o   = c_param_q;
   assign c_size_o    = c_size_q;
   assign c_source_o  = c_source_q;
   assign c_address_o = c_addr_q;
   assign c_corrupt_o = 1'b0;

   assign tag_addr_o  = c_addr_q;
   assign upd_state_o = calc_state;
   assign upd_dirty_o = calc_dirty;
   assign dr_addr_o   = {c_addr_q[ADDR_W-1:6], beat_q, 4'b0000};

   assign busy_o      = (state_q != ST_IDLE);
   assign illegal_o   = illegal_q;

endmodule
